// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg.sv
// Shared encodings and bus types for the fetch/data SRAM arbiter.
package ram_arbiter_pkg;

  localparam int RegBus = 32;
  localparam int RAMBus = 32;
  localparam int SelBus = 4;
  localparam int WdBus  = 8;

  localparam logic RstEnable   = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic RAMWrite_OP = 1'b1;
  localparam logic RAMRead_OP  = 1'b0;

  localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;
  localparam logic [SelBus-1:0] SelAll   = 4'b1111;
  localparam logic [SelBus-1:0] SelNone  = 4'b0000;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ACCESS  = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic              we;
    logic [RAMBus-1:0] addr;
    logic [RAMBus-1:0] data;
    logic [SelBus-1:0] sel;
  } ram_req_t;

  localparam ram_req_t ReqIdle = '{
    we:   RAMRead_OP,
    addr: ZeroWord,
    data: ZeroWord,
    sel:  SelNone
  };

  function automatic ram_req_t fetch_req(
    input logic [RAMBus-1:0] addr
  );
    ram_req_t r;
    r.we   = RAMRead_OP;
    r.addr = addr;
    r.data = ZeroWord;
    r.sel  = SelAll;
    return r;
  endfunction

  function automatic ram_req_t data_req(
    input logic              we,
    input logic [RAMBus-1:0] addr,
    input logic [RAMBus-1:0] data,
    input logic [SelBus-1:0] sel
  );
    ram_req_t r;
    r.we   = we;
    r.addr = addr;
    r.data = data;
    r.sel  = sel;
    return r;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if.sv
// Fetch, data and SRAM-driver signals seen by the arbiter.
interface ram_arbiter_if;
  import ram_arbiter_pkg::*;

  logic              if_req_i;
  logic [RegBus-1:0] if_addr_i;
  logic [RegBus-1:0] if_data_o;
  logic              if_ack_o;

  logic              mem_req_i;
  logic              mem_we_i;
  logic [RegBus-1:0] mem_addr_i;
  logic [RegBus-1:0] mem_data_i;
  logic [SelBus-1:0] mem_sel_i;
  logic [RegBus-1:0] mem_data_o;
  logic              mem_ack_o;

  logic              bus_err_o;
  logic              stall_req_o;

  logic              ram_ce_o;
  logic              ram_we_o;
  logic [RAMBus-1:0] ram_addr_o;
  logic [RAMBus-1:0] ram_data_o;
  logic [SelBus-1:0] ram_sel_o;
  logic              ram_ready_i;
  logic [RAMBus-1:0] ram_data_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  mem_req_i, mem_we_i, mem_addr_i,
    input  mem_data_i, mem_sel_i,
    input  ram_ready_i, ram_data_i,
    output if_data_o, if_ack_o,
    output mem_data_o, mem_ack_o,
    output bus_err_o, stall_req_o,
    output ram_ce_o, ram_we_o, ram_addr_o,
    output ram_data_o, ram_sel_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output mem_req_i, mem_we_i, mem_addr_i,
    output mem_data_i, mem_sel_i,
    output ram_ready_i, ram_data_i,
    input  if_data_o, if_ack_o,
    input  mem_data_o, mem_ack_o,
    input  bus_err_o, stall_req_o,
    input  ram_ce_o, ram_we_o, ram_addr_o,
    input  ram_data_o, ram_sel_o
  );

endinterface

// File: rtl/ram_arbiter_bus_watchdog.sv
// ram_arbiter_bus_watchdog.sv
// Cycle counter that flags an SRAM access which never reports ready.
module bus_watchdog
  import ram_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam logic [WdBus-1:0] Last = WdBus'(TIMEOUT - 1);

  logic [WdBus-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != Last)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == Last);

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter.sv
// Muxes fetch and MEM-stage requests onto the single SRAM driver port.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  ram_arbiter_if.slave bus
);

  arb_state_t        state_q, state_d;
  arb_owner_t        owner_q, owner_d;
  logic              ce_q, ce_d;
  ram_req_t          req_q, req_d;
  logic [RegBus-1:0] if_data_q, if_data_d;
  logic [RegBus-1:0] mem_data_q, mem_data_d;
  logic              if_ack_q, if_ack_d;
  logic              mem_ack_q, mem_ack_d;
  logic              err_q, err_d;
  logic [RegBus-1:0] rdata;
  logic              wd_expired;
  logic              wd_clear;
  logic              wd_en;
  logic              done;

  assign done     = bus.ram_ready_i | wd_expired;
  assign wd_en    = (state_q == ARB_ACCESS);
  assign wd_clear = (state_q != ARB_ACCESS) | done;

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .en     (wd_en),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_FETCH;
      ce_q       <= ChipDisable;
      req_q      <= ReqIdle;
      if_data_q  <= ZeroWord;
      mem_data_q <= ZeroWord;
      if_ack_q   <= 1'b0;
      mem_ack_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      ce_q       <= ce_d;
      req_q      <= req_d;
      if_data_q  <= if_data_d;
      mem_data_q <= mem_data_d;
      if_ack_q   <= if_ack_d;
      mem_ack_q  <= mem_ack_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    ce_d       = ce_q;
    req_d      = req_q;
    if_data_d  = if_data_q;
    mem_data_d = mem_data_q;
    if_ack_d   = 1'b0;
    mem_ack_d  = 1'b0;
    err_d      = 1'b0;
    rdata      = ZeroWord;
    unique case (state_q)
      ARB_IDLE: begin
        // Data side wins ties so a stalled MEM stage drains first.
        if (bus.mem_req_i) begin
          req_d   = data_req(bus.mem_we_i,
                             bus.mem_addr_i,
                             bus.mem_data_i,
                             bus.mem_sel_i);
          owner_d = OWN_DATA;
          ce_d    = ChipEnable;
          state_d = ARB_ACCESS;
        end else if (bus.if_req_i) begin
          req_d   = fetch_req(bus.if_addr_i);
          owner_d = OWN_FETCH;
          ce_d    = ChipEnable;
          state_d = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (done) begin
          unique case (1'b1)
            bus.ram_ready_i: begin
              if (req_q.we == RAMWrite_OP) begin
                rdata = ZeroWord;
              end else begin
                rdata = bus.ram_data_i;
              end
            end
            default: begin
              rdata = ZeroWord;
              err_d = 1'b1;
            end
          endcase
          if (owner_q == OWN_DATA) begin
            mem_data_d = rdata;
            mem_ack_d  = 1'b1;
          end else begin
            if_data_d = rdata;
            if_ack_d  = 1'b1;
          end
          ce_d    = ChipDisable;
          state_d = ARB_RELEASE;
        end
      end
      ARB_RELEASE: begin
        ce_d    = ChipDisable;
        state_d = ARB_IDLE;
      end
      default: begin
        ce_d    = ChipDisable;
        state_d = ARB_IDLE;
      end
    endcase
  end

  assign bus.ram_ce_o    = ce_q;
  assign bus.ram_we_o    = req_q.we;
  assign bus.ram_addr_o  = req_q.addr;
  assign bus.ram_data_o  = req_q.data;
  assign bus.ram_sel_o   = req_q.sel;
  assign bus.if_data_o   = if_data_q;
  assign bus.if_ack_o    = if_ack_q;
  assign bus.mem_data_o  = mem_data_q;
  assign bus.mem_ack_o   = mem_ack_q;
  assign bus.bus_err_o   = err_q;
  assign bus.stall_req_o = (bus.mem_req_i & ~mem_ack_q)
                         | (bus.if_req_i & ~if_ack_q);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter.sv
// Directed scenarios plus randomized traffic against a transaction model.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ram_arbiter_if bus ();

  ram_arbiter #(
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   lat = 1;
  int   dcnt = 0;
  logic ce_prev = 1'b0;
  bit   rise_now = 1'b0;
  int   n_rise = 0;
  int   ce_rise = -1;
  int   ce_rise2 = -1;
  int   mem_ack_at = -1;
  int   if_ack_at = -1;

  bit          model_on = 1'b0;
  bit          act = 1'b0;
  bit          exp_mem = 1'b0;
  bit          exp_err = 1'b0;
  int          exp_ack = 0;
  int          last_ack = -100;
  logic [31:0] exp_rd = 32'h0;
  logic [31:0] held_addr = 32'h0;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'h3C01_1234;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // driver model: ready after lat cycles of chip enable
  always @(posedge clk) dcnt <= bus.ram_ce_o ? dcnt + 1 : 0;
  assign bus.ram_ready_i = bus.ram_ce_o && (dcnt == lat - 1);
  assign bus.ram_data_i  = rd_word(bus.ram_addr_o);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit m_ack;
    bit f_ack;
    m_ack = act && (cyc == exp_ack) && exp_mem;
    f_ack = act && (cyc == exp_ack) && !exp_mem;
    check("stall", 32'(bus.stall_req_o),
          32'((bus.mem_req_i && !m_ack) || (bus.if_req_i && !f_ack)));
    if (rise_now) begin
      check("gap", 32'((cyc - last_ack) >= 2), 1);
      check("rise_idle", 32'(act), 0);
      exp_mem = bus.mem_req_i;
      if (exp_mem) begin
        check("op_addr", bus.ram_addr_o, bus.mem_addr_i);
        check("op_data", bus.ram_data_o, bus.mem_data_i);
        check("op_wesel", 32'({bus.ram_we_o, bus.ram_sel_o}),
              32'({bus.mem_we_i, bus.mem_sel_i}));
      end else begin
        check("op_addr", bus.ram_addr_o, bus.if_addr_i);
        check("op_data", bus.ram_data_o, 32'h0);
        check("op_wesel", 32'({bus.ram_we_o, bus.ram_sel_o}), 32'h0F);
      end
      act       = 1'b1;
      held_addr = bus.ram_addr_o;
      exp_err   = lat > TO;
      exp_ack   = cyc + (exp_err ? TO : lat);
      exp_rd    = (exp_err || bus.ram_we_o) ? 32'h0 : rd_word(bus.ram_addr_o);
    end
    if (bus.mem_ack_o || bus.if_ack_o) begin
      check("ack_act", 32'(act), 1);
      check("ack_when", cyc, exp_ack);
      check("ack_who", 32'({bus.mem_ack_o, bus.if_ack_o}), exp_mem ? 2 : 1);
      check("ack_data", exp_mem ? bus.mem_data_o : bus.if_data_o, exp_rd);
      check("ack_err", 32'(bus.bus_err_o), 32'(exp_err));
      check("ack_ce", 32'(bus.ram_ce_o), 0);
      act      = 1'b0;
      last_ack = cyc;
    end else if (act && cyc >= exp_ack) begin
      check("ack_miss", cyc, 0);
      act = 1'b0;
    end else if (act) begin
      check("hold_ce", 32'(bus.ram_ce_o), 1);
      check("hold_addr", bus.ram_addr_o, held_addr);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    rise_now = bus.ram_ce_o && !ce_prev;
    ce_prev  = bus.ram_ce_o;
    if (rise_now) begin
      n_rise++;
      if (n_rise == 1) ce_rise = cyc;
      else if (n_rise == 2) ce_rise2 = cyc;
    end
    if (bus.mem_ack_o && mem_ack_at < 0) mem_ack_at = cyc;
    if (bus.if_ack_o && if_ack_at < 0) if_ack_at = cyc;
    if (model_on) model_step();
  endtask

  task automatic clr_ev();
    n_rise = 0;
    ce_rise = -1;
    ce_rise2 = -1;
    mem_ack_at = -1;
    if_ack_at = -1;
  endtask

  task automatic settle();
    bus.if_req_i  = 1'b0;
    bus.mem_req_i = 1'b0;
    repeat (3) tick();
    clr_ev();
  endtask

  task automatic mem_go(input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    bus.mem_we_i   = we;
    bus.mem_addr_i = a;
    bus.mem_data_i = d;
    bus.mem_sel_i  = s;
    bus.mem_req_i  = 1'b1;
  endtask

  task automatic wait_mem(input int limit);
    for (int k = 0; k < limit && mem_ack_at < 0; k++) tick();
    check("mem_ack_seen", 32'(mem_ack_at >= 0), 1);
  endtask

  initial begin
    int t0;
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = 32'h0;
    bus.mem_req_i  = 1'b0;
    bus.mem_we_i   = 1'b0;
    bus.mem_addr_i = 32'h0;
    bus.mem_data_i = 32'h0;
    bus.mem_sel_i  = 4'h0;

    rst = 1'b1;
    repeat (3) tick();
    check("rst_ce", 32'(bus.ram_ce_o), 0);
    check("rst_we", 32'(bus.ram_we_o), 0);
    check("rst_addr", bus.ram_addr_o, 0);
    check("rst_wdata", bus.ram_data_o, 0);
    check("rst_sel", 32'(bus.ram_sel_o), 0);
    check("rst_acks", 32'({bus.if_ack_o, bus.mem_ack_o, bus.bus_err_o}), 0);
    check("rst_if_data", bus.if_data_o, 0);
    check("rst_mem_data", bus.mem_data_o, 0);
    rst = 1'b0;
    settle();

    // fetch with 4-cycle driver, stall observed throughout
    lat = 4;
    bus.if_addr_i = 32'h0000_0010;
    bus.if_req_i  = 1'b1;
    t0 = cyc;
    #1;
    check("t6_stall_req", 32'(bus.stall_req_o), 1);
    for (int k = 0; k < 40 && if_ack_at < 0; k++) begin
      tick();
      if (if_ack_at < 0) check("t6_stall_wait", 32'(bus.stall_req_o), 1);
    end
    check("t1_ce_rise", ce_rise - t0, 1);
    check("t1_ack_lat", if_ack_at - ce_rise, 4);
    check("t1_data", bus.if_data_o, 32'h3C01_1234);
    check("t1_sel", 32'(bus.ram_sel_o), 32'hF);
    check("t1_ce_rel", 32'(bus.ram_ce_o), 0);
    check("t6_stall_ack", 32'(bus.stall_req_o), 0);
    bus.if_req_i = 1'b0;
    tick();
    check("t1_ack_pulse", 32'(bus.if_ack_o), 0);
    check("t1_data_hold", bus.if_data_o, 32'h3C01_1234);
    settle();

    // simultaneous requests: data write first, fetch after release
    lat = 2;
    bus.if_addr_i = 32'h0000_0020;
    bus.if_req_i  = 1'b1;
    mem_go(1'b1, 32'h0040_0008, 32'hDEAD_BEEF, 4'hF);
    for (int k = 0; k < 60 && if_ack_at < 0; k++) begin
      tick();
      if (rise_now && n_rise == 1) begin
        check("t2_first_we", 32'(bus.ram_we_o), 1);
        check("t2_first_addr", bus.ram_addr_o, 32'h0040_0008);
        check("t2_first_data", bus.ram_data_o, 32'hDEAD_BEEF);
      end
      if (rise_now && n_rise == 2) begin
        check("t2_second_we", 32'(bus.ram_we_o), 0);
        check("t2_second_addr", bus.ram_addr_o, 32'h0000_0020);
      end
      if (bus.mem_ack_o) begin
        check("t2_wr_data", bus.mem_data_o, 0);
        bus.mem_req_i = 1'b0;
      end
      if (bus.if_ack_o) begin
        check("t2_fetch_data", bus.if_data_o, rd_word(32'h0000_0020));
        bus.if_req_i = 1'b0;
      end
    end
    check("t2_fetch_gap", ce_rise2 - mem_ack_at, 2);
    check("t2_order", 32'(mem_ack_at >= 0 && mem_ack_at < if_ack_at), 1);
    settle();

    // partial-lane write held stable until ready
    lat = 3;
    mem_go(1'b1, 32'h0000_0004, 32'h55AA_1234, 4'b0010);
    for (int k = 0; k < 40 && mem_ack_at < 0; k++) begin
      tick();
      if (bus.ram_ce_o) begin
        check("t3_sel", 32'(bus.ram_sel_o), 32'h2);
        check("t3_early_ack", 32'(bus.mem_ack_o), 0);
      end
    end
    check("t3_ack_lat", mem_ack_at - ce_rise, 3);
    check("t3_err", 32'(bus.bus_err_o), 0);
    settle();

    // hung driver: watchdog abort
    lat = 1000;
    mem_go(1'b0, 32'h0000_0100, 32'h0, 4'hF);
    wait_mem(40);
    check("t4_ack_lat", mem_ack_at - ce_rise, TO);
    check("t4_err", 32'(bus.bus_err_o), 1);
    check("t4_data", bus.mem_data_o, 0);
    bus.mem_req_i = 1'b0;
    tick();
    check("t4_err_pulse", 32'(bus.bus_err_o), 0);
    settle();

    // ready exactly on the last watchdog cycle is not an error
    lat = TO;
    mem_go(1'b0, 32'h0000_0104, 32'h0, 4'hF);
    wait_mem(40);
    check("t4b_ack_lat", mem_ack_at - ce_rise, TO);
    check("t4b_err", 32'(bus.bus_err_o), 0);
    check("t4b_data", bus.mem_data_o, rd_word(32'h0000_0104));
    settle();

    // reset in the middle of a read
    lat = 6;
    mem_go(1'b0, 32'h0000_0040, 32'h0, 4'hF);
    for (int k = 0; k < 10 && n_rise == 0; k++) tick();
    tick();
    rst = 1'b1;
    tick();
    check("t5_ce_rst", 32'(bus.ram_ce_o), 0);
    check("t5_no_ack", 32'({bus.mem_ack_o, bus.bus_err_o}), 0);
    rst = 1'b0;
    clr_ev();
    wait_mem(40);
    check("t5_ack_lat", mem_ack_at - ce_rise, 6);
    check("t5_data", bus.mem_data_o, rd_word(32'h0000_0040));
    settle();

    // randomized traffic checked by the transaction model
    lat = 1;
    act = 1'b0;
    last_ack = -100;
    model_on = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      tick();
      if (bus.mem_ack_o) begin
        bus.mem_req_i = 1'b0;
      end else if (!bus.mem_req_i && n < 1940 &&
                   $urandom_range(0, 3) == 0) begin
        mem_go(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
               $urandom, 4'($urandom_range(0, 15)));
      end
      if (bus.if_ack_o) begin
        bus.if_req_i = 1'b0;
      end else if (!bus.if_req_i && n < 1940 &&
                   $urandom_range(0, 2) == 0) begin
        bus.if_addr_i = $urandom & 32'h0000_FFFC;
        bus.if_req_i  = 1'b1;
      end
      if (!bus.ram_ce_o && $urandom_range(0, 3) == 0) begin
        lat = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 20)
                                          : $urandom_range(1, 4);
      end
    end
    check("drain_idle", 32'(act), 0);
    check("drain_reqs", 32'({bus.mem_req_i, bus.if_req_i}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
